axil_write_ctrl: RTL and testbench
==================================

# axil_write_ctrl

Write-transaction controller for the AXI4-Lite slave. It accepts the AW and W channels independently and in either order, and holds each beat until both are captured. It then drives a single-port register-memory write with byte strobes, waits for the memory acknowledge under a timeout, and returns the B response. It sits between the AXI4-Lite write channels and the register memory, and is the only block that sequences memory writes.

## Interface
- ADDR_WIDTH, 32, AXI address width
- DATA_WIDTH, 32, data width; a multiple of 8
- STRB_WIDTH, DATA_WIDTH/8, byte-strobe width
- BASE_ADDR, 32'h0000_0000, first byte address decoded
- MEM_WORDS, 256, number of memory words decoded; MEM_ADDR width is clog2(MEM_WORDS)
- TIMEOUT, 16, maximum MEM state cycles before abort; ≥1
- clk  in  1  clock; all logic on the rising edge
- resetn  in  1  reset, asynchronous, active-low
- AWVALID  in  1  write-address valid
- AWADDR  in  ADDR_WIDTH  write byte address
- AWREADY  out  1  address accept
- WVALID  in  1  write-data valid
- WDATA  in  DATA_WIDTH  write data
- WSTRB  in  STRB_WIDTH  byte strobes
- WREADY  out  1  data accept
- BVALID  out  1  response valid
- BRESP  out  2  response: 00 OKAY, 10 SLVERR, 11 DECERR
- BREADY  in  1  master accepts response
- MEM_WE  out  1  memory write request; held until acknowledged
- MEM_ADDR  out  clog2(MEM_WORDS)  word index
- MEM_WDATA  out  DATA_WIDTH  registered WDATA
- MEM_WSTRB  out  STRB_WIDTH  registered WSTRB
- MEM_ACK  in  1  memory done; sampled only while MEM_WE=1
- MEM_ERR  in  1  memory error; qualified by MEM_ACK

## Operation
- States: IDLE, ACCEPT, MEM, RESP. Flags: aw_held, w_held.
- IDLE
  - Entered on reset.
  - Moves to ACCEPT unconditionally on the next edge.
- ACCEPT
  - AWREADY = !aw_held and WREADY = !w_held. Both are decoded from registers only, with no combinational path from VALID.
  - AW handshake (AWVALID & AWREADY at an edge): capture AWADDR and set aw_held.
  - W handshake: capture WDATA and WSTRB and set w_held.
  - Both handshakes may occur on the same edge.
  - The edge at which both flags are set (or become set) evaluates the transaction and leaves ACCEPT:
    - Address outside [BASE_ADDR, BASE_ADDR + MEM_WORDS·STRB_WIDTH) → RESP with BRESP=11; no memory access.
    - WSTRB == 0 → RESP with BRESP=00; no memory access.
    - Otherwise → MEM.
  - MEM_ADDR = (AWADDR − BASE_ADDR) >> clog2(STRB_WIDTH). The low address bits are ignored.
- MEM
  - MEM_WE=1; MEM_ADDR, MEM_WDATA and MEM_WSTRB are stable.
  - A timeout counter starts at 0 on entry and increments every cycle.
  - MEM_ACK=1 at an edge → RESP with BRESP = MEM_ERR ? 10 : 00.
  - Counter reaches TIMEOUT−1 without ACK → RESP with BRESP=10. MEM_WE deasserts; a late ACK is ignored.
  - ACK on the final timeout cycle takes priority over the timeout.
- RESP
  - BVALID=1; BRESP is held stable.
  - BVALID & BREADY at an edge → ACCEPT, with aw_held and w_held cleared.
- A second beat on an already-held channel is stalled (READY=0) until the response completes. There is no reordering and no outstanding depth beyond one.
- Reset at any point aborts the transaction: MEM_WE and BVALID drop immediately and no response is issued.

## Timing
- During reset, and in the first cycle after release (IDLE), all outputs are 0: AWREADY, WREADY, BVALID, BRESP, MEM_WE, MEM_ADDR, MEM_WDATA, MEM_WSTRB.
- AWREADY and WREADY are first high in the second cycle after resetn rises.
- Latency with both channels handshaking at edge E0:
  - MEM_WE is high in cycle E0+1.
  - With MEM_ACK high in the same cycle, BVALID is high in cycle E0+2.
  - With BREADY already high, ACCEPT is re-entered at edge E0+2.
  - AWREADY is high again in cycle E0+3.
  - Peak throughput is one write per 3 cycles.
- Memory with k wait cycles (ACK sampled at edge E0+1+k): BVALID rises at cycle E0+2+k.
- Timeout: MEM_WE is high for exactly TIMEOUT cycles; BVALID rises the cycle after.
- DECERR or zero-strobe: BVALID is high in cycle E0+1 and MEM_WE never pulses.
- The B channel holds BVALID and BRESP unchanged through any number of BREADY=0 cycles.

## Test plan
- AW then W three cycles later, addr 0x10, data 0xDEADBEEF, strb 0xF, MEM_ACK tied high → MEM_ADDR=4, one MEM_WE pulse, BRESP=00, AWREADY low while W is pending.
- AW and W in the same cycle, strb 0x3, memory ACK after 2 wait cycles, BREADY low for 4 cycles → MEM_WE high 3 cycles, BVALID held 5 cycles, BRESP=00.
- AWADDR = BASE_ADDR + 4·MEM_WORDS → no MEM_WE, BVALID next cycle, BRESP=11.
- MEM_ACK never asserted, TIMEOUT=16 → MEM_WE high exactly 16 cycles, then BRESP=10; a late ACK has no effect. Separately, ACK with MEM_ERR=1 → BRESP=10.
- WSTRB=0 → no MEM_WE, BRESP=00. Back-to-back writes with BREADY held high → AWREADY spacing of 3 cycles.
- resetn pulled low while in MEM → MEM_WE drops asynchronously, no BVALID, and AWREADY high again two cycles after release.

Source files
------------

// File: rtl/axil_write_ctrl.sv
// AXI4-Lite write-channel controller: captures AW and W in any order, issues one
// strobed register-memory write under a timeout, then returns the B response.
module axil_write_ctrl #(
    parameter int unsigned             ADDR_WIDTH = 32,
    parameter int unsigned             DATA_WIDTH = 32,
    parameter int unsigned             STRB_WIDTH = DATA_WIDTH / 8,
    parameter logic [ADDR_WIDTH-1:0]   BASE_ADDR  = '0,
    parameter int unsigned             MEM_WORDS  = 256,
    parameter int unsigned             TIMEOUT    = 16
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         AWVALID,
    input  logic [ADDR_WIDTH-1:0]        AWADDR,
    output logic                         AWREADY,
    input  logic                         WVALID,
    input  logic [DATA_WIDTH-1:0]        WDATA,
    input  logic [STRB_WIDTH-1:0]        WSTRB,
    output logic                         WREADY,
    output logic                         BVALID,
    output logic [1:0]                   BRESP,
    input  logic                         BREADY,
    output logic                         MEM_WE,
    output logic [$clog2(MEM_WORDS)-1:0] MEM_ADDR,
    output logic [DATA_WIDTH-1:0]        MEM_WDATA,
    output logic [STRB_WIDTH-1:0]        MEM_WSTRB,
    input  logic                         MEM_ACK,
    input  logic                         MEM_ERR
);

    localparam int unsigned SHIFT = $clog2(STRB_WIDTH);
    localparam int unsigned MA_W  = $clog2(MEM_WORDS);
    localparam int unsigned CW    = $clog2(TIMEOUT) + 1;
    localparam logic [63:0] SPAN  = 64'(MEM_WORDS) * 64'(STRB_WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        ACCEPT,
        MEM,
        RESP
    } state_t;

    state_t                  state;
    logic                    aw_held;
    logic                    w_held;
    logic                    addr_ok;
    logic [CW-1:0]           tcnt;

    logic                    aw_hs;
    logic                    w_hs;
    logic                    both_now;
    logic                    ok_now;
    logic                    aw_in_range;
    logic [ADDR_WIDTH-1:0]   offset;
    logic [STRB_WIDTH-1:0]   strb_now;

    // Handshake readiness is decoded purely from state and held flags.
    assign AWREADY = (state == ACCEPT) && !aw_held;
    assign WREADY  = (state == ACCEPT) && !w_held;
    assign MEM_WE  = (state == MEM);
    assign BVALID  = (state == RESP);

    assign aw_hs       = AWVALID && AWREADY;
    assign w_hs        = WVALID && WREADY;
    assign offset      = AWADDR - BASE_ADDR;
    assign aw_in_range = (AWADDR >= BASE_ADDR) && (64'(offset) < SPAN);

    // The decision edge may coincide with either capture, so look through to the inputs.
    assign both_now = (aw_held || aw_hs) && (w_held || w_hs);
    assign ok_now   = aw_hs ? aw_in_range : addr_ok;
    assign strb_now = w_hs ? WSTRB : MEM_WSTRB;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            addr_ok   <= 1'b0;
            tcnt      <= '0;
            BRESP     <= '0;
            MEM_ADDR  <= '0;
            MEM_WDATA <= '0;
            MEM_WSTRB <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state <= ACCEPT;
                end
                ACCEPT: begin
                    if (aw_hs) begin
                        aw_held  <= 1'b1;
                        addr_ok  <= aw_in_range;
                        MEM_ADDR <= MA_W'(offset >> SHIFT);
                    end
                    if (w_hs) begin
                        w_held    <= 1'b1;
                        MEM_WDATA <= WDATA;
                        MEM_WSTRB <= WSTRB;
                    end
                    if (both_now) begin
                        tcnt <= '0;
                        if (!ok_now) begin
                            state <= RESP;
                            BRESP <= 2'b11;
                        end else if (strb_now == '0) begin
                            state <= RESP;
                            BRESP <= 2'b00;
                        end else begin
                            state <= MEM;
                        end
                    end
                end
                MEM: begin
                    // An acknowledge on the last allowed cycle wins over the timeout.
                    if (MEM_ACK) begin
                        state <= RESP;
                        BRESP <= MEM_ERR ? 2'b10 : 2'b00;
                    end else if (tcnt == CW'(TIMEOUT - 1)) begin
                        state <= RESP;
                        BRESP <= 2'b10;
                    end else begin
                        tcnt <= tcnt + CW'(1);
                    end
                end
                RESP: begin
                    if (BREADY) begin
                        state   <= ACCEPT;
                        aw_held <= 1'b0;
                        w_held  <= 1'b0;
                        BRESP   <= 2'b00;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axil_write_ctrl.sv
// Scoreboard bench for axil_write_ctrl: directed writes push expected memory
// writes and B responses; a negedge monitor pops and compares them.
module tb_axil_write_ctrl;

    typedef struct packed {
        logic [7:0]  a;
        logic [31:0] d;
        logic [3:0]  s;
    } mem_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        AWVALID, WVALID, BREADY;
    logic [31:0] AWADDR, WDATA;
    logic [3:0]  WSTRB;
    logic        AWREADY, WREADY, BVALID, MEM_WE;
    logic [1:0]  BRESP;
    logic [7:0]  MEM_ADDR;
    logic [31:0] MEM_WDATA;
    logic [3:0]  MEM_WSTRB;
    logic        MEM_ACK = 1'b0;
    logic        MEM_ERR = 1'b0;

    mem_t       exp_mem[$];
    logic [1:0] exp_b[$];
    mem_t       m;
    logic [1:0] b;

    int checks = 0, failures = 0;
    int cyc = 0, we_cycles = 0, bv_cycles = 0, mem_cyc = 0;
    int ack_delay = 0;
    logic err_mode = 1'b0, force_ack = 1'b0;

    axil_write_ctrl #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .STRB_WIDTH(4),
        .BASE_ADDR (32'h0000_0000),
        .MEM_WORDS (256),
        .TIMEOUT   (16)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .AWVALID  (AWVALID),
        .AWADDR   (AWADDR),
        .AWREADY  (AWREADY),
        .WVALID   (WVALID),
        .WDATA    (WDATA),
        .WSTRB    (WSTRB),
        .WREADY   (WREADY),
        .BVALID   (BVALID),
        .BRESP    (BRESP),
        .BREADY   (BREADY),
        .MEM_WE   (MEM_WE),
        .MEM_ADDR (MEM_ADDR),
        .MEM_WDATA(MEM_WDATA),
        .MEM_WSTRB(MEM_WSTRB),
        .MEM_ACK  (MEM_ACK),
        .MEM_ERR  (MEM_ERR)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Memory model: acknowledge after ack_delay wait cycles (negative = never).
    always @(posedge clk) begin
        #1;
        if (MEM_WE) mem_cyc++;
        else        mem_cyc = 0;
        MEM_ACK = force_ack || (MEM_WE && ack_delay >= 0 && mem_cyc > ack_delay);
        MEM_ERR = err_mode;
    end

    always @(negedge clk) begin
        if (MEM_WE) we_cycles++;
        if (BVALID) bv_cycles++;
        if (MEM_WE && MEM_ACK) begin
            check("mem_expected", exp_mem.size() != 0, 1);
            if (exp_mem.size() != 0) begin
                m = exp_mem.pop_front();
                check("mem_addr", MEM_ADDR, m.a);
                check("mem_wdata", MEM_WDATA, m.d);
                check("mem_wstrb", MEM_WSTRB, m.s);
            end
        end
        if (BVALID && BREADY) begin
            check("b_expected", exp_b.size() != 0, 1);
            if (exp_b.size() != 0) begin
                b = exp_b.pop_front();
                check("bresp", BRESP, b);
            end
        end
    end

    task automatic send_aw(input logic [31:0] a);
        int n;
        AWVALID = 1'b1;
        AWADDR  = a;
        for (n = 0; n < 100; n++) begin
            @(negedge clk);
            if (AWREADY) break;
        end
        check("aw_accept", n < 100, 1);
        @(posedge clk); #1;
        AWVALID = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        int n;
        WVALID = 1'b1;
        WDATA  = d;
        WSTRB  = s;
        for (n = 0; n < 100; n++) begin
            @(negedge clk);
            if (WREADY) break;
        end
        check("w_accept", n < 100, 1);
        @(posedge clk); #1;
        WVALID = 1'b0;
    endtask

    task automatic write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        fork
            send_aw(a);
            send_w(d, s);
        join
    endtask

    // Returns how many cycles after the accepting edge BVALID is first seen.
    task automatic wait_bv(output int lat);
        int n;
        for (n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (BVALID) break;
        end
        lat = n;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, wb, bb, n;
        int t[3];
        resetn = 1'b0; AWVALID = 1'b0; WVALID = 1'b0; BREADY = 1'b1;
        AWADDR = '0; WDATA = '0; WSTRB = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {AWREADY, WREADY, BVALID, BRESP, MEM_WE, MEM_ADDR, MEM_WDATA, MEM_WSTRB}, 0);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(negedge clk);
        check("idle_outputs", {AWREADY, WREADY, BVALID, BRESP, MEM_WE, MEM_ADDR, MEM_WDATA, MEM_WSTRB}, 0);
        @(negedge clk);
        check("ready_after_reset", {AWREADY, WREADY}, 2'b11);
        @(posedge clk); #1;

        // AW first, W three cycles later
        exp_mem.push_back(mem_t'{8'd4, 32'hDEAD_BEEF, 4'hF});
        exp_b.push_back(2'b00);
        wb = we_cycles;
        send_aw(32'h10);
        @(negedge clk);
        check("aw_stall_w_pending", {AWREADY, WREADY}, 2'b01);
        @(posedge clk); #1;
        @(posedge clk); #1;
        send_w(32'hDEAD_BEEF, 4'hF);
        wait_bv(lat);
        check("t1_latency", lat, 2);
        @(posedge clk); #1;
        check("t1_we_cycles", we_cycles - wb, 1);

        // Simultaneous AW/W, two wait cycles, BREADY low for four cycles
        BREADY = 1'b0; ack_delay = 2;
        exp_mem.push_back(mem_t'{8'd8, 32'h1234_5678, 4'h3});
        exp_b.push_back(2'b00);
        wb = we_cycles; bb = bv_cycles;
        write(32'h20, 32'h1234_5678, 4'h3);
        wait_bv(lat);
        check("t2_latency", lat, 4);
        repeat (3) @(negedge clk);
        check("t2_bresp_held", {BVALID, BRESP}, 3'b100);
        @(posedge clk); #1;
        BREADY = 1'b1;
        @(posedge clk); #1;
        check("t2_we_cycles", we_cycles - wb, 3);
        check("t2_bv_cycles", bv_cycles - bb, 5);
        ack_delay = 0;

        // One past the decoded range
        exp_b.push_back(2'b11);
        wb = we_cycles;
        write(32'h400, 32'hCAFE_F00D, 4'hF);
        wait_bv(lat);
        check("decerr_latency", lat, 1);
        @(posedge clk); #1;
        check("decerr_no_we", we_cycles - wb, 0);

        // Last decoded word, low address bits ignored
        exp_mem.push_back(mem_t'{8'd255, 32'hA5A5_A5A5, 4'h8});
        exp_b.push_back(2'b00);
        write(32'h3FF, 32'hA5A5_A5A5, 4'h8);
        wait_bv(lat);
        check("top_word_latency", lat, 2);
        @(posedge clk); #1;

        // Timeout with a late acknowledge during the response
        ack_delay = -1; BREADY = 1'b0;
        exp_b.push_back(2'b10);
        wb = we_cycles;
        write(32'h40, 32'h1111_2222, 4'hF);
        wait_bv(lat);
        check("timeout_latency", lat, 17);
        force_ack = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("late_ack_ignored", {BVALID, BRESP}, 3'b110);
        BREADY = 1'b1;
        @(posedge clk); #1;
        force_ack = 1'b0;
        check("timeout_we_cycles", we_cycles - wb, 16);
        ack_delay = 0;
        @(posedge clk); #1;

        // Memory error on acknowledge
        err_mode = 1'b1;
        exp_mem.push_back(mem_t'{8'd2, 32'h0BAD_F00D, 4'hF});
        exp_b.push_back(2'b10);
        write(32'h8, 32'h0BAD_F00D, 4'hF);
        wait_bv(lat);
        check("memerr_latency", lat, 2);
        @(posedge clk); #1;
        err_mode = 1'b0;

        // Zero strobes
        exp_b.push_back(2'b00);
        wb = we_cycles;
        write(32'h30, 32'hFFFF_FFFF, 4'h0);
        wait_bv(lat);
        check("zero_strb_latency", lat, 1);
        @(posedge clk); #1;
        check("zero_strb_no_we", we_cycles - wb, 0);

        // Back-to-back writes with BREADY held high
        for (int i = 0; i < 3; i++) begin
            exp_mem.push_back(mem_t'{8'(8'h14 + i), 32'(32'h100 + i), 4'hF});
            exp_b.push_back(2'b00);
        end
        AWVALID = 1'b1; WVALID = 1'b1; WSTRB = 4'hF;
        for (int i = 0; i < 3; i++) begin
            AWADDR = 32'h50 + 32'(4 * i);
            WDATA  = 32'h100 + 32'(i);
            for (n = 0; n < 50; n++) begin
                @(negedge clk);
                if (AWREADY && WREADY) break;
            end
            t[i] = cyc;
            @(posedge clk); #1;
        end
        AWVALID = 1'b0; WVALID = 1'b0;
        check("b2b_spacing_0", t[1] - t[0], 3);
        check("b2b_spacing_1", t[2] - t[1], 3);
        for (n = 0; n < 50; n++) begin
            @(negedge clk);
            if (exp_b.size() == 0) break;
        end
        @(posedge clk); #1;
        check("b2b_drained", exp_b.size(), 0);

        // Reset while the memory write is outstanding
        ack_delay = -1;
        bb = bv_cycles;
        write(32'h0, 32'h5555_AAAA, 4'hF);
        @(posedge clk); #3;
        check("in_mem_before_reset", MEM_WE, 1);
        resetn = 1'b0;
        #1;
        check("reset_abort", {MEM_WE, BVALID}, 2'b00);
        @(posedge clk); #1;
        @(posedge clk); #1;
        resetn = 1'b1;
        ack_delay = 0;
        @(negedge clk);
        check("post_reset_idle", AWREADY, 0);
        @(negedge clk);
        check("post_reset_ready", AWREADY, 1);
        check("no_resp_after_abort", bv_cycles - bb, 0);

        check("mem_queue_empty", exp_mem.size(), 0);
        check("b_queue_empty", exp_b.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
